// File: rtl/perceptron_train_table.sv
// Multi-table perceptron weight store. It has registered parallel prediction reads, saturating
// +/-1 training updates, and a clear sweep after reset.
module perceptron_train_table #(
    parameter int unsigned NUM_TABLES   = 4,
    parameter int unsigned ENTRIES      = 256,
    parameter int unsigned NUM_WEIGHTS  = 8,
    parameter int unsigned WEIGHT_WIDTH = 6,
    parameter int unsigned BIAS_ENTRIES = 512,
    parameter int unsigned BIAS_WIDTH   = 8,
    localparam int unsigned AW    = $clog2(ENTRIES),
    localparam int unsigned BW    = $clog2(BIAS_ENTRIES),
    localparam int unsigned ROW_W = NUM_WEIGHTS * WEIGHT_WIDTH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_pred_valid,
    input  logic [NUM_TABLES*AW-1:0]         i_read_addrs,
    input  logic [BW-1:0]                    i_bias_read_addr,
    output logic                             o_pred_valid_out,
    output logic [NUM_TABLES*ROW_W-1:0]      o_read_data,
    output logic [BIAS_WIDTH-1:0]            o_bias_read_data,
    input  logic                             i_train_valid,
    output logic                             o_train_ready,
    input  logic [NUM_TABLES*AW-1:0]         i_train_addrs,
    input  logic [BW-1:0]                    i_train_bias_addr,
    input  logic [NUM_TABLES*NUM_WEIGHTS-1:0] i_train_dir,
    input  logic                             i_train_bias_dir,
    output logic                             o_train_done,
    output logic                             o_init_busy
);

    localparam int unsigned SWEEP = (ENTRIES > BIAS_ENTRIES) ? ENTRIES : BIAS_ENTRIES;
    localparam int unsigned IW    = $clog2(SWEEP);
    localparam logic [IW:0] ENT_L  = (IW+1)'(ENTRIES);
    localparam logic [IW:0] BENT_L = (IW+1)'(BIAS_ENTRIES);
    localparam logic [IW-1:0] IDX_LAST = IW'(SWEEP - 1);

    typedef enum logic [1:0] {StInit, StIdle, StUpdate} state_t;

    logic [ROW_W-1:0]      r_tbl  [NUM_TABLES][ENTRIES];
    logic [BIAS_WIDTH-1:0] r_bias [BIAS_ENTRIES];

    state_t                           r_state;
    logic [IW-1:0]                    r_idx;
    logic                             r_pred_valid_out;
    logic [NUM_TABLES*ROW_W-1:0]      r_read_data;
    logic [BIAS_WIDTH-1:0]            r_bias_read_data;
    logic                             r_train_ready;
    logic                             r_train_done;
    logic                             r_init_busy;
    logic [NUM_TABLES*AW-1:0]         r_upd_addrs;
    logic [BW-1:0]                    r_upd_bias_addr;
    logic [NUM_TABLES*NUM_WEIGHTS-1:0] r_upd_dir;
    logic                             r_upd_bias_dir;
    logic [NUM_TABLES*ROW_W-1:0]      r_upd_rows;
    logic [BIAS_WIDTH-1:0]            r_upd_bias;

    logic [NUM_TABLES*ROW_W-1:0] w_new_rows;
    logic [BIAS_WIDTH-1:0]       w_new_bias;
    logic                        w_init_tbl_we;
    logic                        w_init_bias_we;
    logic                        w_upd_we;

    function automatic logic [WEIGHT_WIDTH-1:0] step_w(input logic [WEIGHT_WIDTH-1:0] v,
                                                       input logic up);
        logic [WEIGHT_WIDTH-1:0] vmax;
        logic [WEIGHT_WIDTH-1:0] vmin;
        logic [WEIGHT_WIDTH-1:0] one;
        vmax = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
        vmin = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
        one  = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
        if (up) return (v == vmax) ? v : v + one;
        else    return (v == vmin) ? v : v - one;
    endfunction

    function automatic logic [BIAS_WIDTH-1:0] step_b(input logic [BIAS_WIDTH-1:0] v,
                                                     input logic up);
        logic [BIAS_WIDTH-1:0] vmax;
        logic [BIAS_WIDTH-1:0] vmin;
        logic [BIAS_WIDTH-1:0] one;
        vmax = {1'b0, {(BIAS_WIDTH-1){1'b1}}};
        vmin = {1'b1, {(BIAS_WIDTH-1){1'b0}}};
        one  = {{(BIAS_WIDTH-1){1'b0}}, 1'b1};
        if (up) return (v == vmax) ? v : v + one;
        else    return (v == vmin) ? v : v - one;
    endfunction

    always_comb begin
        w_new_rows = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            for (int w = 0; w < NUM_WEIGHTS; w++) begin
                w_new_rows[(t*NUM_WEIGHTS+w)*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
                    step_w(r_upd_rows[(t*NUM_WEIGHTS+w)*WEIGHT_WIDTH +: WEIGHT_WIDTH],
                           r_upd_dir[t*NUM_WEIGHTS+w]);
            end
        end
        w_new_bias = step_b(r_upd_bias, r_upd_bias_dir);
    end

    // Writes are gated by reset so a reset during UPDATE drops the pending commit.
    assign w_init_tbl_we  = (r_state == StInit) && !i_rst && ({1'b0, r_idx} < ENT_L);
    assign w_init_bias_we = (r_state == StInit) && !i_rst && ({1'b0, r_idx} < BENT_L);
    assign w_upd_we       = (r_state == StUpdate) && !i_rst;

    always_ff @(posedge i_clk) begin
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (w_init_tbl_we) begin
                r_tbl[t][r_idx[AW-1:0]] <= '0;
            end else if (w_upd_we) begin
                r_tbl[t][r_upd_addrs[t*AW +: AW]] <= w_new_rows[t*ROW_W +: ROW_W];
            end
        end
        if (w_init_bias_we) begin
            r_bias[r_idx[BW-1:0]] <= '0;
        end else if (w_upd_we) begin
            r_bias[r_upd_bias_addr] <= w_new_bias;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= StInit;
            r_idx            <= '0;
            r_pred_valid_out <= 1'b0;
            r_read_data      <= '0;
            r_bias_read_data <= '0;
            r_train_ready    <= 1'b0;
            r_train_done     <= 1'b0;
            r_init_busy      <= 1'b1;
        end else begin
            // Reads sample pre-write contents, so a same-edge collision returns the old row.
            if (i_pred_valid && r_state != StInit) begin
                r_pred_valid_out <= 1'b1;
                for (int t = 0; t < NUM_TABLES; t++) begin
                    r_read_data[t*ROW_W +: ROW_W] <= r_tbl[t][i_read_addrs[t*AW +: AW]];
                end
                r_bias_read_data <= r_bias[i_bias_read_addr];
            end else begin
                r_pred_valid_out <= 1'b0;
            end
            r_train_done <= 1'b0;
            unique case (r_state)
                StInit: begin
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == IDX_LAST) begin
                        r_idx         <= '0;
                        r_state       <= StIdle;
                        r_init_busy   <= 1'b0;
                        r_train_ready <= 1'b1;
                    end
                end
                StIdle: begin
                    if (i_train_valid) begin
                        r_state         <= StUpdate;
                        r_train_ready   <= 1'b0;
                        r_train_done    <= 1'b1;
                        r_upd_addrs     <= i_train_addrs;
                        r_upd_bias_addr <= i_train_bias_addr;
                        r_upd_dir       <= i_train_dir;
                        r_upd_bias_dir  <= i_train_bias_dir;
                        for (int t = 0; t < NUM_TABLES; t++) begin
                            r_upd_rows[t*ROW_W +: ROW_W] <= r_tbl[t][i_train_addrs[t*AW +: AW]];
                        end
                        r_upd_bias <= r_bias[i_train_bias_addr];
                    end
                end
                StUpdate: begin
                    r_state       <= StIdle;
                    r_train_ready <= 1'b1;
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign o_pred_valid_out = r_pred_valid_out;
    assign o_read_data      = r_read_data;
    assign o_bias_read_data = r_bias_read_data;
    assign o_train_ready    = r_train_ready;
    assign o_train_done     = r_train_done;
    assign o_init_busy      = r_init_busy;

endmodule

// File: tb/tb_perceptron_train_table.sv
// Directed scoreboard bench for perceptron_train_table with default parameters.
module tb_perceptron_train_table;

    logic         clk = 1'b0;
    logic         rst;
    logic         pred_valid;
    logic [31:0]  read_addrs;
    logic [8:0]   bias_read_addr;
    logic         pred_valid_out;
    logic [191:0] read_data;
    logic [7:0]   bias_read_data;
    logic         train_valid;
    logic         train_ready;
    logic [31:0]  train_addrs;
    logic [8:0]   train_bias_addr;
    logic [31:0]  train_dir;
    logic         train_bias_dir;
    logic         train_done;
    logic         init_busy;

    typedef struct packed {
        logic [191:0] d;
        logic [7:0]   b;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    always #5 clk = ~clk;

    perceptron_train_table dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pred_valid     (pred_valid),
        .i_read_addrs     (read_addrs),
        .i_bias_read_addr (bias_read_addr),
        .o_pred_valid_out (pred_valid_out),
        .o_read_data      (read_data),
        .o_bias_read_data (bias_read_data),
        .i_train_valid    (train_valid),
        .o_train_ready    (train_ready),
        .i_train_addrs    (train_addrs),
        .i_train_bias_addr(train_bias_addr),
        .i_train_dir      (train_dir),
        .i_train_bias_dir (train_bias_dir),
        .o_train_done     (train_done),
        .o_init_busy      (init_busy)
    );

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Tables flagged in tmask carry odd/even weight values; other tables read 0.
    function automatic logic [191:0] rowval(input logic [3:0] tmask, input logic [5:0] odd,
                                            input logic [5:0] even);
        logic [191:0] r;
        r = '0;
        for (int t = 0; t < 4; t++)
            for (int w = 0; w < 8; w++)
                if (tmask[t]) r[(t*8+w)*6 +: 6] = (w % 2 == 1) ? odd : even;
        return r;
    endfunction

    function automatic logic [191:0] rep(input logic [5:0] v);
        return rowval(4'hF, v, v);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (train_done === 1'b1) n_done++;
            if (pred_valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected pred_valid_out", 192'd1, 192'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("read_data", read_data, e.d);
                    check("bias_read_data", {184'd0, bias_read_data}, {184'd0, e.b});
                end
            end
        end
    end

    task automatic issue_pred(input logic [31:0] a, input logic [8:0] ba,
                              input logic [191:0] ed, input logic [7:0] eb);
        exp_t e;
        pred_valid     = 1'b1;
        read_addrs     = a;
        bias_read_addr = ba;
        e.d = ed;
        e.b = eb;
        sb_q.push_back(e);
        @(posedge clk); #1;
        pred_valid = 1'b0;
    endtask

    task automatic check_hold(input logic [191:0] ed, input logic [7:0] eb);
        @(posedge clk); #1;
        check("pred_valid_out idle", {191'd0, pred_valid_out}, 192'd0);
        check("read_data hold", read_data, ed);
        check("bias hold", {184'd0, bias_read_data}, {184'd0, eb});
    endtask

    task automatic accept_train(input logic [31:0] a, input logic [8:0] ba,
                                input logic [31:0] dir, input logic bdir);
        int k;
        train_addrs     = a;
        train_bias_addr = ba;
        train_dir       = dir;
        train_bias_dir  = bdir;
        train_valid     = 1'b1;
        k = 0;
        while (train_ready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) check("train_ready timeout", 192'd0, 192'd1);
        @(posedge clk); #1;
        train_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] a, input logic [8:0] ba,
                         input logic [31:0] dir, input logic bdir);
        accept_train(a, ba, dir, bdir);
        @(posedge clk); #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_reset_state();
        check("rst init_busy", {191'd0, init_busy}, 192'd1);
        check("rst train_ready", {191'd0, train_ready}, 192'd0);
        check("rst train_done", {191'd0, train_done}, 192'd0);
        check("rst pred_valid_out", {191'd0, pred_valid_out}, 192'd0);
        check("rst read_data", read_data, 192'd0);
        check("rst bias_read_data", {184'd0, bias_read_data}, 192'd0);
    endtask

    initial begin
        int   n;
        int   d0;
        int   acc;
        logic [9:0] rseq;
        logic [7:0] ra;
        logic [8:0] rb;

        rst = 1'b1;
        pred_valid = 1'b0;
        read_addrs = '0;
        bias_read_addr = '0;
        train_valid = 1'b0;
        train_addrs = '0;
        train_bias_addr = '0;
        train_dir = '0;
        train_bias_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();

        // Sweep with pred_valid held high: every request must be ignored.
        rst = 1'b0;
        pred_valid = 1'b1;
        count_busy(n);
        pred_valid = 1'b0;
        check("init sweep length", 192'(n), 192'd512);
        check("ready after sweep", {191'd0, train_ready}, 192'd1);

        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 9'($urandom_range(0, 511));
            issue_pred({4{ra}}, rb, 192'd0, 8'd0);
        end

        d0 = n_done;
        repeat (40) train({4{8'd5}}, 9'd9, 32'hFFFF_FFFF, 1'b1);
        check("train_done count 40", 192'(n_done - d0), 192'd40);
        issue_pred({4{8'd5}}, 9'd9, rep(6'h1F), 8'h28);
        check_hold(rep(6'h1F), 8'h28);
        issue_pred({8'd0, 8'd0, 8'd0, 8'd5}, 9'd9, rowval(4'b0001, 6'h1F, 6'h1F), 8'h28);

        repeat (80) train({4{8'd5}}, 9'd10, 32'h0, 1'b0);
        issue_pred({4{8'd5}}, 9'd10, rep(6'h20), 8'hB0);
        train({4{8'd5}}, 9'd10, 32'hFFFF_FFFF, 1'b1);
        issue_pred({4{8'd5}}, 9'd10, rep(6'h21), 8'hB1);

        repeat (200) train({4{8'd6}}, 9'd9, 32'hFFFF_FFFF, 1'b1);
        issue_pred({4{8'd6}}, 9'd9, rep(6'h1F), 8'h7F);

        // Distinct rows per table, alternating direction per weight.
        train({8'd23, 8'd22, 8'd21, 8'd20}, 9'd11, {4{8'hAA}}, 1'b0);
        issue_pred({8'd23, 8'd22, 8'd21, 8'd20}, 9'd11, rowval(4'hF, 6'h01, 6'h3F), 8'hFF);
        issue_pred({4{8'd20}}, 9'd11, rowval(4'b0001, 6'h01, 6'h3F), 8'hFF);

        // Collision: read in the UPDATE cycle sees the old row.
        accept_train({4{8'd7}}, 9'd7, 32'hFFFF_FFFF, 1'b1);
        issue_pred({4{8'd7}}, 9'd7, 192'd0, 8'd0);
        issue_pred({4{8'd7}}, 9'd7, rep(6'h01), 8'h01);

        d0 = n_done;
        acc = 0;
        rseq = '0;
        train_addrs = {4{8'd30}};
        train_bias_addr = 9'd30;
        train_dir = 32'hFFFF_FFFF;
        train_bias_dir = 1'b1;
        train_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rseq[i] = train_ready;
            if (train_ready === 1'b1) acc++;
            @(posedge clk); #1;
        end
        train_valid = 1'b0;
        check("b2b accepts", 192'(acc), 192'd5);
        check("b2b done pulses", 192'(n_done - d0), 192'd5);
        check("b2b ready pattern", {182'd0, rseq}, {182'd0, 10'b0101010101});
        issue_pred({4{8'd30}}, 9'd30, rep(6'h05), 8'h05);

        // Reset during UPDATE.
        accept_train({4{8'd40}}, 9'd40, 32'hFFFF_FFFF, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state();
        rst = 1'b0;
        count_busy(n);
        check("resweep length", 192'(n), 192'd512);
        issue_pred({4{8'd40}}, 9'd40, 192'd0, 8'd0);
        issue_pred({4{8'd5}}, 9'd9, 192'd0, 8'd0);

        // Reset partway into the sweep restarts it from idx 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("busy mid sweep", {191'd0, init_busy}, 192'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        check("restart sweep length", 192'(n), 192'd512);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard drained", 192'(sb_q.size()), 192'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
